psum_gbf_dbuf: RTL
==================

PSUM_GBF_DBUF -- requirements
Module: psum_gbf_dbuf

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, 512, word width of a psum GBF entry.
REQ-002 SHALL have parameter ADDR_BITWIDTH, 5, entry address width.
REQ-003 SHALL have parameter DEPTH, 32, entries per bank.
REQ-004 SHALL have parameter LANE_BITWIDTH, 16, per-lane psum width; lanes = DATA_BITWIDTH/LANE_BITWIDTH (32).
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port w_en  in  1  accumulate-write strobe from su_adder stage.
REQ-008 SHALL have port w_addr  in  ADDR_BITWIDTH  accumulate-write address.
REQ-009 SHALL have port w_num  in  1  bank select (0/1) for accumulate write, init write and read.
REQ-010 SHALL have port w_data  in  DATA_BITWIDTH  incoming partial sums.
REQ-011 SHALL have port r_en  in  1  read strobe.
REQ-012 SHALL have port r_addr  in  ADDR_BITWIDTH  read address.
REQ-013 SHALL have port r_data  out  DATA_BITWIDTH  read data.
REQ-014 SHALL have port init_en  in  1  zero-initialise strobe.
REQ-015 SHALL have port init_addr  in  ADDR_BITWIDTH  zero-initialise address.
REQ-016 SHALL have port drain_start  in  1  pulse: start draining bank drain_bank.
REQ-017 SHALL have port drain_bank  in  1  bank to drain, sampled on drain_start.
REQ-018 SHALL have port drain_valid  out  1  drain word valid.
REQ-019 SHALL have port drain_ready  in  1  consumer accepts drain word.
REQ-020 SHALL have port drain_data  out  DATA_BITWIDTH  drained word.
REQ-021 SHALL have port drain_addr  out  ADDR_BITWIDTH  address of drain_data.
REQ-022 SHALL have port drain_done  out  1  one-cycle pulse after last word accepted.
REQ-023 SHALL have port busy  out  2  per-bank draining flag.
REQ-024 SHALL have port wr_conflict  out  1  one-cycle pulse: write/init targeted a draining bank.

Function
REQ-025 SHALL hold two banks of DEPTH x DATA_BITWIDTH words.
REQ-026 w_en: mem[w_num][w_addr] <= per-lane (mem + w_data) mod 2^LANE_BITWIDTH, no saturation, no cross-lane carry; visible to reads next cycle.
REQ-027 init_en: mem[w_num][init_addr] <= 0.
REQ-028 init_en and w_en same cycle, same address: stored value = w_data (init applied first); different addresses: both performed.
REQ-029 r_en: r_data = mem[w_num][r_addr] one cycle later; r_data holds when r_en low.
REQ-030 Read of address written in the same cycle SHALL return pre-write value.
REQ-031 Drain FSM states IDLE, RD, SEND, DONE.
REQ-032 IDLE: drain_start -> RD, latch bank, counter = 0, busy[bank] = 1; drain_start outside IDLE ignored.
REQ-033 RD: issue internal read of counter -> SEND next cycle with drain_valid = 1, drain_addr = counter.
REQ-034 SEND: drain_data/drain_addr stable while drain_valid & !drain_ready; on handshake, counter = DEPTH-1 -> DONE, else counter+1 and -> RD.
REQ-035 DONE: drain_done = 1 one cycle, busy[bank] = 0, -> IDLE.
REQ-036 Drain port read SHALL not disturb r_data or user read port.
REQ-037 w_en or init_en to a bank with busy set: write dropped, wr_conflict pulses next cycle; other bank unaffected.

Reset
REQ-038 reset SHALL force FSM IDLE, counter 0, busy 0, drain_valid 0, drain_done 0, wr_conflict 0, r_data 0, drain_data 0, drain_addr 0.
REQ-039 reset SHALL NOT clear memory; reset mid-drain abandons drain without drain_done.

Verification
REQ-040 init bank0 addr3, then w_en addr3 w_data lanes = 0x0001 twice -> read addr3 returns all lanes 0x0002.
REQ-041 mem lane = 0xFFFF, w_data lane 0x0002 -> lane 0x0001, neighbour lane unchanged.
REQ-042 drain bank1 with drain_ready always 1 -> 32 words, addr 0..31, drain_done at cycle 2*32+1 after start.
REQ-043 drain with drain_ready low 3 cycles at addr 5 -> drain_data/addr held, no word lost or repeated.
REQ-044 w_en to bank1 while draining bank1 -> data unchanged, wr_conflict pulse; w_en bank0 same cycle-window succeeds.
REQ-045 reset asserted at drain addr 10 -> drain_valid 0, busy 0 next cycle, no drain_done; new drain_start restarts at addr 0.

Source files
------------

// File: rtl/psum_gbf_dbuf_if.sv
// psum_gbf_dbuf_if: accumulate/init/read ports and drain stream of the psum global buffer.
interface psum_gbf_dbuf_if #(
    parameter int DATA_BITWIDTH = 512,
    parameter int ADDR_BITWIDTH = 5
);
    logic                     w_en;
    logic [ADDR_BITWIDTH-1:0] w_addr;
    logic                     w_num;
    logic [DATA_BITWIDTH-1:0] w_data;
    logic                     r_en;
    logic [ADDR_BITWIDTH-1:0] r_addr;
    logic [DATA_BITWIDTH-1:0] r_data;
    logic                     init_en;
    logic [ADDR_BITWIDTH-1:0] init_addr;
    logic                     drain_start;
    logic                     drain_bank;
    logic                     drain_valid;
    logic                     drain_ready;
    logic [DATA_BITWIDTH-1:0] drain_data;
    logic [ADDR_BITWIDTH-1:0] drain_addr;
    logic                     drain_done;
    logic [1:0]               busy;
    logic                     wr_conflict;

    modport master (
        output w_en, w_addr, w_num, w_data, r_en, r_addr, init_en, init_addr,
               drain_start, drain_bank, drain_ready,
        input  r_data, drain_valid, drain_data, drain_addr, drain_done, busy, wr_conflict
    );

    modport slave (
        input  w_en, w_addr, w_num, w_data, r_en, r_addr, init_en, init_addr,
               drain_start, drain_bank, drain_ready,
        output r_data, drain_valid, drain_data, drain_addr, drain_done, busy, wr_conflict
    );
endinterface

// File: rtl/psum_gbf_dbuf.sv
// psum_gbf_dbuf: two-bank psum buffer with lane-wise accumulate, zero-init, read port
// and a ready/valid drain engine that locks the drained bank against writes.
module psum_gbf_dbuf #(
    parameter int DATA_BITWIDTH = 512,
    parameter int ADDR_BITWIDTH = 5,
    parameter int DEPTH         = 32,
    parameter int LANE_BITWIDTH = 16
) (
    input logic            clk,
    input logic            reset,
    psum_gbf_dbuf_if.slave bus
);
    localparam int LANES = DATA_BITWIDTH / LANE_BITWIDTH;

    typedef enum logic [1:0] {IDLE, RD, SEND, DONE} state_t;

    state_t                   state;
    logic [DATA_BITWIDTH-1:0] mem [2][DEPTH];
    logic [DATA_BITWIDTH-1:0] acc;
    logic [ADDR_BITWIDTH-1:0] cnt;
    logic                     bank;
    logic                     blocked;
    logic                     wr_ok;
    logic                     init_ok;
    logic                     collide;

    assign blocked = bus.busy[bus.w_num];
    assign wr_ok   = bus.w_en & !blocked;
    assign init_ok = bus.init_en & !blocked;
    assign collide = init_ok && bus.init_addr == bus.w_addr;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign acc[i*LANE_BITWIDTH +: LANE_BITWIDTH] = mem[bus.w_num][bus.w_addr][i*LANE_BITWIDTH +: LANE_BITWIDTH]
                                                     + bus.w_data[i*LANE_BITWIDTH +: LANE_BITWIDTH];
    end

    // Storage is deliberately not reset; a same-address init zeroes before the accumulate.
    always_ff @(posedge clk) begin
        if (init_ok) mem[bus.w_num][bus.init_addr] <= '0;
        if (wr_ok) mem[bus.w_num][bus.w_addr] <= collide ? bus.w_data : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.r_data      <= '0;
            bus.wr_conflict <= 1'b0;
        end else begin
            if (bus.r_en) bus.r_data <= mem[bus.w_num][bus.r_addr];
            bus.wr_conflict <= (bus.w_en | bus.init_en) & blocked;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bank            <= 1'b0;
            bus.busy        <= '0;
            bus.drain_valid <= 1'b0;
            bus.drain_done  <= 1'b0;
            bus.drain_data  <= '0;
            bus.drain_addr  <= '0;
        end else begin
            bus.drain_done <= 1'b0;
            case (state)
                IDLE: if (bus.drain_start) begin
                    state                      <= RD;
                    bank                       <= bus.drain_bank;
                    cnt                        <= '0;
                    bus.busy[bus.drain_bank]   <= 1'b1;
                end
                RD: begin
                    bus.drain_data  <= mem[bank][cnt];
                    bus.drain_addr  <= cnt;
                    bus.drain_valid <= 1'b1;
                    state           <= SEND;
                end
                SEND: if (bus.drain_ready) begin
                    bus.drain_valid <= 1'b0;
                    if (cnt == ADDR_BITWIDTH'(DEPTH - 1)) state <= DONE;
                    else begin
                        cnt   <= cnt + 1'b1;
                        state <= RD;
                    end
                end
                DONE: begin
                    bus.drain_done <= 1'b1;
                    bus.busy[bank] <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
